rob_complete: RTL and testbench

//   Reorder buffer and complete/retire stage that receives the issue stage's three FU result buses.

---
 rtl/rob_complete.sv | 215 +++++++++++++++++++++
 tb/tb_rob_complete.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_complete.sv
// Reorder buffer with result write-back, one-cycle forwarding broadcast and
// in-order dual retire to the architectural file and free list.
module rob_complete #(
  parameter  int DEPTH = 16,
  parameter  int DW    = 32,
  parameter  int PW    = 6,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          alloc_valid_1,
  input  logic          alloc_valid_2,
  input  logic [PW-1:0] rob_p_1,
  input  logic [PW-1:0] rob_p_2,
  input  logic [PW-1:0] o_rob_p_1,
  input  logic [PW-1:0] o_rob_p_2,
  input  logic [6:0]    rob_op_1,
  input  logic [6:0]    rob_op_2,
  output logic          alloc_ready,
  output logic [IW-1:0] alloc_idx_1,
  output logic [IW-1:0] alloc_idx_2,

  input  logic          result_valid_1,
  input  logic [IW-1:0] result_ROB_1,
  input  logic [PW-1:0] result_dest_1,
  input  logic [DW-1:0] result_1,
  input  logic          result_valid_2,
  input  logic [IW-1:0] result_ROB_2,
  input  logic [PW-1:0] result_dest_2,
  input  logic [DW-1:0] result_2,
  input  logic          result_valid_3,
  input  logic [IW-1:0] result_ROB_3,
  input  logic [PW-1:0] result_dest_3,
  input  logic [DW-1:0] result_3,

  output logic          f_flag_1,
  output logic [PW-1:0] dest_r_1,
  output logic [DW-1:0] f_data_1,
  output logic          f_flag_2,
  output logic [PW-1:0] dest_r_2,
  output logic [DW-1:0] f_data_2,
  output logic          f_flag_3,
  output logic [PW-1:0] dest_r_3,
  output logic [DW-1:0] f_data_3,

  output logic          retire_valid_1,
  output logic          retire_valid_2,
  output logic [PW-1:0] retire_pd_1,
  output logic [PW-1:0] retire_pd_2,
  output logic [PW-1:0] retire_old_pd_1,
  output logic [PW-1:0] retire_old_pd_2,
  output logic [DW-1:0] retire_data_1,
  output logic [DW-1:0] retire_data_2,
  output logic [IW:0]   rob_count
);

  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_done;
  logic [PW-1:0]    ent_pd     [DEPTH];
  logic [PW-1:0]    ent_old_pd [DEPTH];
  logic [6:0]       ent_op     [DEPTH];
  logic [DW-1:0]    ent_data   [DEPTH];

  logic [IW-1:0] head;
  logic [IW-1:0] tail;
  logic [IW-1:0] head_p1;
  logic [IW-1:0] tail_p1;
  logic [IW:0]   count;

  logic          acc_1;
  logic          acc_2;
  logic          ret_1;
  logic          ret_2;
  logic [IW:0]   n_alloc;
  logic [IW:0]   n_ret;
  logic          store_1;
  logic          store_2;

  assign head_p1 = head + IW'(1);
  assign tail_p1 = tail + IW'(1);

  assign alloc_ready = (count <= (IW+1)'(DEPTH - 2));
  assign alloc_idx_1 = tail;
  assign alloc_idx_2 = tail_p1;
  assign rob_count   = count;

  // Slot 2 is only honoured together with the program-older slot 1.
  assign acc_1 = alloc_ready & alloc_valid_1;
  assign acc_2 = acc_1 & alloc_valid_2;

  assign ret_1 = ent_valid[head] & ent_done[head];
  assign ret_2 = ret_1 & ent_valid[head_p1] & ent_done[head_p1];

  assign n_alloc = (IW+1)'(acc_1) + (IW+1)'(acc_2);
  assign n_ret   = (IW+1)'(ret_1) + (IW+1)'(ret_2);

  assign store_1 = (ent_op[head]    == OP_STORE);
  assign store_2 = (ent_op[head_p1] == OP_STORE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + IW'(n_ret);
      tail  <= tail + IW'(n_alloc);
      count <= count + n_alloc - n_ret;
    end
  end

  // Write order matters: completion, then retire clear, then allocation, so
  // the latest event on a shared index wins and later FUs override earlier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_valid[i]  <= 1'b0;
        ent_done[i]   <= 1'b0;
        ent_pd[i]     <= '0;
        ent_old_pd[i] <= '0;
        ent_op[i]     <= '0;
        ent_data[i]   <= '0;
      end
    end else begin
      if (result_valid_1 && ent_valid[result_ROB_1]) begin
        ent_done[result_ROB_1] <= 1'b1;
        ent_data[result_ROB_1] <= result_1;
      end
      if (result_valid_2 && ent_valid[result_ROB_2]) begin
        ent_done[result_ROB_2] <= 1'b1;
        ent_data[result_ROB_2] <= result_2;
      end
      if (result_valid_3 && ent_valid[result_ROB_3]) begin
        ent_done[result_ROB_3] <= 1'b1;
        ent_data[result_ROB_3] <= result_3;
      end

      if (ret_1) begin
        ent_valid[head] <= 1'b0;
        ent_done[head]  <= 1'b0;
      end
      if (ret_2) begin
        ent_valid[head_p1] <= 1'b0;
        ent_done[head_p1]  <= 1'b0;
      end

      if (acc_1) begin
        ent_valid[tail]  <= 1'b1;
        ent_done[tail]   <= 1'b0;
        ent_pd[tail]     <= rob_p_1;
        ent_old_pd[tail] <= o_rob_p_1;
        ent_op[tail]     <= rob_op_1;
      end
      if (acc_2) begin
        ent_valid[tail_p1]  <= 1'b1;
        ent_done[tail_p1]   <= 1'b0;
        ent_pd[tail_p1]     <= rob_p_2;
        ent_old_pd[tail_p1] <= o_rob_p_2;
        ent_op[tail_p1]     <= rob_op_2;
      end
    end
  end

  // Forwarding is a plain one-cycle delay of the FU buses, regardless of entry state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_flag_1 <= 1'b0;
      dest_r_1 <= '0;
      f_data_1 <= '0;
      f_flag_2 <= 1'b0;
      dest_r_2 <= '0;
      f_data_2 <= '0;
      f_flag_3 <= 1'b0;
      dest_r_3 <= '0;
      f_data_3 <= '0;
    end else begin
      f_flag_1 <= result_valid_1;
      dest_r_1 <= result_dest_1;
      f_data_1 <= result_1;
      f_flag_2 <= result_valid_2;
      dest_r_2 <= result_dest_2;
      f_data_2 <= result_2;
      f_flag_3 <= result_valid_3;
      dest_r_3 <= result_dest_3;
      f_data_3 <= result_3;
    end
  end

  // Stores have no destination: nothing is committed and nothing is freed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_valid_1  <= 1'b0;
      retire_valid_2  <= 1'b0;
      retire_pd_1     <= '0;
      retire_pd_2     <= '0;
      retire_old_pd_1 <= '0;
      retire_old_pd_2 <= '0;
      retire_data_1   <= '0;
      retire_data_2   <= '0;
    end else begin
      retire_valid_1  <= ret_1;
      retire_valid_2  <= ret_2;
      retire_pd_1     <= (ret_1 && !store_1) ? ent_pd[head]        : '0;
      retire_old_pd_1 <= (ret_1 && !store_1) ? ent_old_pd[head]    : '0;
      retire_data_1   <= ret_1               ? ent_data[head]      : '0;
      retire_pd_2     <= (ret_2 && !store_2) ? ent_pd[head_p1]     : '0;
      retire_old_pd_2 <= (ret_2 && !store_2) ? ent_old_pd[head_p1] : '0;
      retire_data_2   <= ret_2               ? ent_data[head_p1]   : '0;
    end
  end

endmodule

// File: tb/tb_rob_complete.sv
// Directed bench for rob_complete: stimulus pushes expected retire/forward
// records into queues, an independent negedge monitor pops and compares.
module tb_rob_complete;
  localparam logic [6:0] OP_ALU = 7'b0110011;
  localparam logic [6:0] OP_ST  = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alloc_valid_1, alloc_valid_2;
  logic [5:0]  rob_p_1, rob_p_2, o_rob_p_1, o_rob_p_2;
  logic [6:0]  rob_op_1, rob_op_2;
  logic        alloc_ready;
  logic [3:0]  alloc_idx_1, alloc_idx_2;
  logic        result_valid_1, result_valid_2, result_valid_3;
  logic [3:0]  result_ROB_1, result_ROB_2, result_ROB_3;
  logic [5:0]  result_dest_1, result_dest_2, result_dest_3;
  logic [31:0] result_1, result_2, result_3;
  logic        f_flag_1, f_flag_2, f_flag_3;
  logic [5:0]  dest_r_1, dest_r_2, dest_r_3;
  logic [31:0] f_data_1, f_data_2, f_data_3;
  logic        retire_valid_1, retire_valid_2;
  logic [5:0]  retire_pd_1, retire_pd_2, retire_old_pd_1, retire_old_pd_2;
  logic [31:0] retire_data_1, retire_data_2;
  logic [4:0]  rob_count;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [5:0]  pd;
    logic [5:0]  old;
    logic [31:0] data;
  } ret_t;
  typedef struct {
    logic [5:0]  dest;
    logic [31:0] data;
  } fwd_t;

  ret_t exp_q[$];
  fwd_t fq1[$], fq2[$], fq3[$];

  rob_complete dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid_1(alloc_valid_1), .alloc_valid_2(alloc_valid_2),
    .rob_p_1(rob_p_1), .rob_p_2(rob_p_2),
    .o_rob_p_1(o_rob_p_1), .o_rob_p_2(o_rob_p_2),
    .rob_op_1(rob_op_1), .rob_op_2(rob_op_2),
    .alloc_ready(alloc_ready), .alloc_idx_1(alloc_idx_1), .alloc_idx_2(alloc_idx_2),
    .result_valid_1(result_valid_1), .result_ROB_1(result_ROB_1),
    .result_dest_1(result_dest_1), .result_1(result_1),
    .result_valid_2(result_valid_2), .result_ROB_2(result_ROB_2),
    .result_dest_2(result_dest_2), .result_2(result_2),
    .result_valid_3(result_valid_3), .result_ROB_3(result_ROB_3),
    .result_dest_3(result_dest_3), .result_3(result_3),
    .f_flag_1(f_flag_1), .dest_r_1(dest_r_1), .f_data_1(f_data_1),
    .f_flag_2(f_flag_2), .dest_r_2(dest_r_2), .f_data_2(f_data_2),
    .f_flag_3(f_flag_3), .dest_r_3(dest_r_3), .f_data_3(f_data_3),
    .retire_valid_1(retire_valid_1), .retire_valid_2(retire_valid_2),
    .retire_pd_1(retire_pd_1), .retire_pd_2(retire_pd_2),
    .retire_old_pd_1(retire_old_pd_1), .retire_old_pd_2(retire_old_pd_2),
    .retire_data_1(retire_data_1), .retire_data_2(retire_data_2),
    .rob_count(rob_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic mon_ret(input string name, input logic [5:0] pd, input logic [5:0] old,
                         input logic [31:0] data);
    ret_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s unexpected retire pd=%0d data=%0h required=none", name, pd, data);
    end else begin
      e = exp_q.pop_front();
      check({name, "_pd"}, 64'(pd), 64'(e.pd));
      check({name, "_old_pd"}, 64'(old), 64'(e.old));
      check({name, "_data"}, 64'(data), 64'(e.data));
    end
  endtask

  task automatic mon_fwd(input int k, input logic [5:0] dest, input logic [31:0] data);
    fwd_t e;
    int   sz;
    sz = (k == 1) ? fq1.size() : (k == 2) ? fq2.size() : fq3.size();
    if (sz == 0) begin
      checks++;
      failures++;
      $display("FAIL fwd%0d unexpected f_flag dest=%0d required=none", k, dest);
    end else begin
      if (k == 1) e = fq1.pop_front();
      else if (k == 2) e = fq2.pop_front();
      else e = fq3.pop_front();
      check($sformatf("fwd%0d_dest", k), 64'(dest), 64'(e.dest));
      check($sformatf("fwd%0d_data", k), 64'(data), 64'(e.data));
    end
  endtask

  always @(negedge clk) begin
    if (retire_valid_2 && !retire_valid_1) begin
      checks++;
      failures++;
      $display("FAIL retire_order retire_valid_2=1 required retire_valid_1=1");
    end
    if (retire_valid_1) mon_ret("ret1", retire_pd_1, retire_old_pd_1, retire_data_1);
    if (retire_valid_2) mon_ret("ret2", retire_pd_2, retire_old_pd_2, retire_data_2);
    if (f_flag_1) mon_fwd(1, dest_r_1, f_data_1);
    if (f_flag_2) mon_fwd(2, dest_r_2, f_data_2);
    if (f_flag_3) mon_fwd(3, dest_r_3, f_data_3);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid_1 = 0; alloc_valid_2 = 0;
    result_valid_1 = 0; result_valid_2 = 0; result_valid_3 = 0;
  endtask

  task automatic flush_model();
    exp_q.delete(); fq1.delete(); fq2.delete(); fq3.delete();
  endtask

  task automatic do_alloc(input bit v2, input logic [5:0] p1, input logic [5:0] o1,
                          input logic [6:0] op1, input logic [31:0] d1,
                          input logic [5:0] p2, input logic [5:0] o2,
                          input logic [6:0] op2, input logic [31:0] d2, input bit accept);
    ret_t e;
    alloc_valid_1 = 1; alloc_valid_2 = v2;
    rob_p_1 = p1; o_rob_p_1 = o1; rob_op_1 = op1;
    rob_p_2 = p2; o_rob_p_2 = o2; rob_op_2 = op2;
    if (accept) begin
      e.pd = (op1 == OP_ST) ? 6'd0 : p1; e.old = (op1 == OP_ST) ? 6'd0 : o1; e.data = d1;
      exp_q.push_back(e);
      if (v2) begin
        e.pd = (op2 == OP_ST) ? 6'd0 : p2; e.old = (op2 == OP_ST) ? 6'd0 : o2; e.data = d2;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic do_result(input int k, input logic [3:0] idx, input logic [5:0] dest,
                           input logic [31:0] data);
    fwd_t e;
    e.dest = dest; e.data = data;
    case (k)
      1: begin result_valid_1 = 1; result_ROB_1 = idx; result_dest_1 = dest; result_1 = data; fq1.push_back(e); end
      2: begin result_valid_2 = 1; result_ROB_2 = idx; result_dest_2 = dest; result_2 = data; fq2.push_back(e); end
      default: begin result_valid_3 = 1; result_ROB_3 = idx; result_dest_3 = dest; result_3 = data; fq3.push_back(e); end
    endcase
  endtask

  // Fill/wrap phase: program-order number j lives at index (6+j)%16, pd 40+j, old j+1, data 0x1000+j.
  task automatic alloc_j(input int j, input bit accept);
    do_alloc(1, 6'(40 + j), 6'(j + 1), (j == 0) ? OP_ST : OP_ALU, 32'h1000 + 32'(j),
             6'(41 + j), 6'(j + 2), OP_ALU, 32'h1000 + 32'(j + 1), accept);
  endtask

  task automatic res_j(input int k, input int idx);
    int j;
    j = (idx + 10) % 16;
    do_result(k, 4'(idx), 6'(40 + j), 32'h1000 + 32'(j));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle();
    rob_p_1 = 0; rob_p_2 = 0; o_rob_p_1 = 0; o_rob_p_2 = 0; rob_op_1 = 0; rob_op_2 = 0;
    result_ROB_1 = 0; result_ROB_2 = 0; result_ROB_3 = 0;
    result_dest_1 = 0; result_dest_2 = 0; result_dest_3 = 0;
    result_1 = 0; result_2 = 0; result_3 = 0;

    // 1: reset values
    tick(); tick();
    check("rst_alloc_ready", 64'(alloc_ready), 1);
    check("rst_alloc_idx_1", 64'(alloc_idx_1), 0);
    check("rst_alloc_idx_2", 64'(alloc_idx_2), 1);
    check("rst_count", 64'(rob_count), 0);
    check("rst_retire_valid_1", 64'(retire_valid_1), 0);
    check("rst_f_flag_1", 64'(f_flag_1), 0);
    rst_n = 1;

    // 2: basic alloc / complete out of order / dual retire
    do_alloc(1, 6'd33, 6'd3, OP_ALU, 32'd5, 6'd34, 6'd4, OP_ALU, 32'd7, 1);
    tick(); idle();
    check("t2_count", 64'(rob_count), 2);
    check("t2_alloc_idx_1", 64'(alloc_idx_1), 2);
    do_result(1, 4'd1, 6'd34, 32'd7);
    tick(); idle();
    check("t2_f_flag_a", 64'(f_flag_1), 1);
    check("t2_dest_r_a", 64'(dest_r_1), 34);
    check("t2_f_data_a", 64'(f_data_1), 7);
    do_result(1, 4'd0, 6'd33, 32'd5);
    tick(); idle();
    check("t2_f_flag_b", 64'(f_flag_1), 1);
    check("t2_no_early_retire", 64'(retire_valid_1), 0);
    tick();
    check("t2_rv1", 64'(retire_valid_1), 1);
    check("t2_rv2", 64'(retire_valid_2), 1);
    check("t2_data_1", 64'(retire_data_1), 5);
    check("t2_data_2", 64'(retire_data_2), 7);
    check("t2_old_1", 64'(retire_old_pd_1), 3);
    check("t2_old_2", 64'(retire_old_pd_2), 4);
    check("t2_f_flag_drop", 64'(f_flag_1), 0);
    tick();
    check("t2_count_empty", 64'(rob_count), 0);
    check("t2_rv1_idle", 64'(retire_valid_1), 0);

    // 3: head blocks retire until it completes (entries 2..5)
    do_alloc(1, 6'd10, 6'd20, OP_ALU, 32'd100, 6'd11, 6'd21, OP_ALU, 32'd101, 1);
    tick(); idle();
    do_alloc(1, 6'd12, 6'd22, OP_ALU, 32'd102, 6'd13, 6'd23, OP_ALU, 32'd103, 1);
    tick(); idle();
    do_result(1, 4'd3, 6'd11, 32'd101);
    do_result(2, 4'd4, 6'd12, 32'd102);
    do_result(3, 4'd5, 6'd13, 32'd103);
    tick(); idle();
    tick(); tick();
    check("t3_blocked", 64'(retire_valid_1), 0);
    check("t3_count", 64'(rob_count), 4);
    do_result(2, 4'd2, 6'd10, 32'd100);
    tick(); idle();
    check("t3_latency", 64'(retire_valid_1), 0);
    tick();
    check("t3_rv2_a", 64'(retire_valid_2), 1);
    check("t3_count_a", 64'(rob_count), 2);
    tick();
    check("t3_rv2_b", 64'(retire_valid_2), 1);
    check("t3_count_b", 64'(rob_count), 0);
    tick();
    check("t3_rv1_idle", 64'(retire_valid_1), 0);

    // 4: fill all 16 entries starting at index 6 (tail wraps through 15->0)
    for (int c = 0; c < 8; c++) begin
      alloc_j(2 * c, 1);
      tick(); idle();
      if (c == 4) begin
        check("t4_wrap_idx_1", 64'(alloc_idx_1), 0);
        check("t4_wrap_idx_2", 64'(alloc_idx_2), 1);
      end
      if (c == 6) check("t4_ready_at_14", 64'(alloc_ready), 1);
    end
    check("t4_full_count", 64'(rob_count), 16);
    check("t4_full_ready", 64'(alloc_ready), 0);
    alloc_j(16, 0);
    tick(); idle();
    check("t4_ignored_count", 64'(rob_count), 16);
    check("t4_ignored_idx", 64'(alloc_idx_1), 6);
    res_j(1, 6); res_j(2, 7);
    tick(); idle();
    check("t4_still_full", 64'(alloc_ready), 0);
    tick();
    check("t4_rv2", 64'(retire_valid_2), 1);
    check("t4_store_pd", 64'(retire_pd_1), 0);
    check("t4_count_14", 64'(rob_count), 14);
    check("t4_ready_again", 64'(alloc_ready), 1);

    // 5: alloc 2 + retire 2 at count 14, head wraps 15->0
    res_j(1, 8); res_j(2, 9); res_j(3, 10);
    tick(); idle();
    res_j(1, 11); res_j(2, 12); res_j(3, 13); alloc_j(16, 1);
    tick(); idle();
    check("t5_count_f2", 64'(rob_count), 14);
    check("t5_idx_f2", 64'(alloc_idx_1), 8);
    check("t5_rv2_f2", 64'(retire_valid_2), 1);
    res_j(1, 14); res_j(2, 15); res_j(3, 0); alloc_j(18, 1);
    tick(); idle();
    check("t5_count_f3", 64'(rob_count), 14);
    check("t5_idx_f3", 64'(alloc_idx_1), 10);
    res_j(1, 1); alloc_j(20, 1);
    tick(); idle();
    check("t5_count_f4", 64'(rob_count), 14);
    check("t5_idx_f4", 64'(alloc_idx_1), 12);
    tick();
    check("t5_count_f5", 64'(rob_count), 12);
    check("t5_rv2_f5", 64'(retire_valid_2), 1);
    tick();
    check("t5_count_f6", 64'(rob_count), 10);
    check("t5_rv2_f6", 64'(retire_valid_2), 1);
    tick();
    check("t5_blocked_f7", 64'(retire_valid_1), 0);
    check("t5_count_f7", 64'(rob_count), 10);
    check("t5_fwd_drained", 64'(fq1.size() + fq2.size() + fq3.size()), 0);

    // 6: reset mid-stream with 5 in flight, two already completed
    rst_n = 0; flush_model();
    tick(); tick();
    rst_n = 1;
    check("t6_count_clean", 64'(rob_count), 0);
    do_alloc(1, 6'd50, 6'd1, OP_ALU, 32'hAA, 6'd51, 6'd2, OP_ALU, 32'hBB, 1);
    tick(); idle();
    do_alloc(1, 6'd52, 6'd3, OP_ALU, 32'd0, 6'd53, 6'd4, OP_ALU, 32'd0, 1);
    tick(); idle();
    do_alloc(0, 6'd54, 6'd5, OP_ALU, 32'd0, 6'd0, 6'd0, OP_ALU, 32'd0, 1);
    do_result(1, 4'd0, 6'd50, 32'hAA);
    do_result(2, 4'd1, 6'd51, 32'hBB);
    tick(); idle();
    check("t6_count_5", 64'(rob_count), 5);
    check("t6_f_flag_pre", 64'(f_flag_1), 1);
    #1;
    rst_n = 0; flush_model();
    #1;
    check("t6_async_count", 64'(rob_count), 0);
    check("t6_async_f_flag", 64'(f_flag_1), 0);
    check("t6_async_f_data", 64'(f_data_1), 0);
    check("t6_async_dest_r_2", 64'(dest_r_2), 0);
    check("t6_async_idx", 64'(alloc_idx_1), 0);
    check("t6_async_ready", 64'(alloc_ready), 1);
    tick();
    rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("t6_no_stale_retire", 64'(retire_valid_1), 0);
      check("t6_count_zero", 64'(rob_count), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
